// File: rtl/move_sequencer_if.sv
// rtl/move_sequencer_if.sv - drop request, board memory and logic unit signals of the move sequencer
interface move_sequencer_if #(
  parameter int NUM_ROWS = 6
);
  logic                drop_req;
  logic [2:0]          drop_col;
  logic                drop_ack;
  logic                drop_err;
  logic                busy;
  logic [2:0]          mem_addr;
  logic                mem_wr;
  logic [NUM_ROWS-1:0] onoff_rd;
  logic [NUM_ROWS-1:0] player_rd;
  logic [NUM_ROWS-1:0] onoff_wr;
  logic [NUM_ROWS-1:0] player_wr;
  logic                lu_go;
  logic [1:0]          lu_result;
  logic                cur_player;
  logic [5:0]          move_count;
  logic                game_over;
  logic [1:0]          winner;

  modport slave (
    input  drop_req, drop_col, onoff_rd, player_rd, lu_result,
    output drop_ack, drop_err, busy, mem_addr, mem_wr, onoff_wr, player_wr,
           lu_go, cur_player, move_count, game_over, winner
  );

  modport master (
    output drop_req, drop_col, onoff_rd, player_rd, lu_result,
    input  drop_ack, drop_err, busy, mem_addr, mem_wr, onoff_wr, player_wr,
           lu_go, cur_player, move_count, game_over, winner
  );
endinterface

// File: rtl/move_sequencer.sv
// rtl/move_sequencer.sv - sequences one Connect Four move: read column, validate, write back, evaluate
module move_sequencer #(
  parameter int NUM_COLS    = 7,
  parameter int NUM_ROWS    = 6,
  parameter int RESULT_WAIT = 1
) (
  input logic             clk,
  input logic             reset,
  move_sequencer_if.slave bus
);
  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_CHECK, S_WRITE, S_WAIT, S_EVAL, S_ERR, S_OVER
  } state_t;

  localparam logic [3:0] COL_LIMIT = 4'(NUM_COLS);
  localparam logic [5:0] TOTAL     = 6'(NUM_COLS * NUM_ROWS);
  localparam logic [7:0] WAIT_LOAD = 8'(RESULT_WAIT - 1);

  state_t              state;
  logic [2:0]          col_q;
  logic [NUM_ROWS-1:0] onoff_q;
  logic [NUM_ROWS-1:0] player_q;
  logic [7:0]          wait_cnt;
  logic                ack_q, err_q, busy_q, wr_q, go_q;
  logic                player_q_cur;
  logic [5:0]          count_q;
  logic                over_q;
  logic [1:0]          winner_q;

  logic [2:0]          height;
  logic                therm;
  logic                hole;
  logic                full;
  logic [NUM_ROWS-1:0] placed;

  // Height counts set bits; a set bit above a clear one breaks the thermometer shape.
  always_comb begin
    height = '0;
    therm  = 1'b1;
    hole   = 1'b0;
    placed = bus.player_rd;
    for (int i = 0; i < NUM_ROWS; i++) begin
      if (bus.onoff_rd[i]) begin
        if (hole) therm = 1'b0;
        height = height + 3'd1;
      end else begin
        hole = 1'b1;
      end
    end
    for (int i = 0; i < NUM_ROWS; i++) begin
      if (height == 3'(i)) placed[i] = player_q_cur;
    end
    full = &bus.onoff_rd;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      col_q        <= '0;
      onoff_q      <= '0;
      player_q     <= '0;
      wait_cnt     <= '0;
      ack_q        <= 1'b0;
      err_q        <= 1'b0;
      busy_q       <= 1'b0;
      wr_q         <= 1'b0;
      go_q         <= 1'b0;
      player_q_cur <= 1'b0;
      count_q      <= '0;
      over_q       <= 1'b0;
      winner_q     <= '0;
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      wr_q  <= 1'b0;
      go_q  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.drop_req) begin
            col_q  <= bus.drop_col;
            busy_q <= 1'b1;
            if ({1'b0, bus.drop_col} >= COL_LIMIT) begin
              state <= S_ERR;
              err_q <= 1'b1;
            end else begin
              state <= S_READ;
            end
          end
        end
        S_READ: state <= S_CHECK;
        S_CHECK: begin
          if (!therm || full) begin
            state <= S_ERR;
            err_q <= 1'b1;
          end else begin
            onoff_q  <= {bus.onoff_rd[NUM_ROWS-2:0], 1'b1};
            player_q <= placed;
            state    <= S_WRITE;
            wr_q     <= 1'b1;
            go_q     <= 1'b1;
          end
        end
        S_WRITE: begin
          count_q  <= count_q + 6'd1;
          wait_cnt <= WAIT_LOAD;
          state    <= S_WAIT;
        end
        S_WAIT: begin
          if (wait_cnt == 8'd0) begin
            state <= S_EVAL;
            ack_q <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - 8'd1;
          end
        end
        S_EVAL: begin
          // Reserved result 11 falls through to the draw/continue decision.
          if (bus.lu_result == 2'b01 || bus.lu_result == 2'b10) begin
            winner_q <= bus.lu_result;
            over_q   <= 1'b1;
            state    <= S_OVER;
          end else if (count_q == TOTAL) begin
            winner_q <= 2'b11;
            over_q   <= 1'b1;
            state    <= S_OVER;
          end else begin
            player_q_cur <= ~player_q_cur;
            busy_q       <= 1'b0;
            state        <= S_IDLE;
          end
        end
        S_ERR: begin
          busy_q <= 1'b0;
          state  <= S_IDLE;
        end
        S_OVER: state <= S_OVER;
        default: begin
          busy_q <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.drop_ack   = ack_q;
  assign bus.drop_err   = err_q;
  assign bus.busy       = busy_q;
  assign bus.mem_addr   = col_q;
  assign bus.mem_wr     = wr_q;
  assign bus.lu_go      = go_q;
  assign bus.onoff_wr   = onoff_q;
  assign bus.player_wr  = player_q;
  assign bus.cur_player = player_q_cur;
  assign bus.move_count = count_q;
  assign bus.game_over  = over_q;
  assign bus.winner     = winner_q;
endmodule

// File: tb/tb_move_sequencer.sv
// tb/tb_move_sequencer.sv - self-checking bench for move_sequencer with a move-level reference model
module tb_move_sequencer;
  localparam int RW = 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  move_sequencer_if #(.NUM_ROWS(6)) bus();

  move_sequencer #(.NUM_COLS(7), .NUM_ROWS(6), .RESULT_WAIT(RW)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  // Board memory: synchronous read, written by the DUT strobe or by bench preload.
  logic [5:0] mem_o [0:7];
  logic [5:0] mem_p [0:7];
  logic       pl_en;
  logic [2:0] pl_col;
  logic [5:0] pl_o, pl_p;
  always @(posedge clk) begin
    if (pl_en) begin
      mem_o[pl_col] <= pl_o;
      mem_p[pl_col] <= pl_p;
    end else if (bus.mem_wr) begin
      mem_o[bus.mem_addr] <= bus.onoff_wr;
      mem_p[bus.mem_addr] <= bus.player_wr;
    end
    bus.onoff_rd  <= mem_o[bus.mem_addr];
    bus.player_rd <= mem_p[bus.mem_addr];
  end

  int n_checks = 0;
  int n_errors = 0;

  logic       m_player, p_player;
  logic [5:0] m_count, p_count;
  logic       m_over, p_over;
  logic [1:0] m_winner, p_winner;
  logic [5:0] v_o [0:7];
  logic [5:0] v_p [0:7];
  int         kind, k, end_k;
  logic [2:0] mv_col;
  logic [5:0] e_onoff, e_player;
  int         ack_k, err_k, wr_k, ack_total, err_total, wr_total;
  logic [5:0] cap_onoff, cap_player;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic is_therm(input logic [5:0] o);
    int c;
    c = $countones(o);
    return ((32'd1 << c) - 32'd1) == {26'd0, o};
  endfunction

  task automatic compare();
    logic eack, eerr, ewr, ebusy, mid;
    if (kind != 0) k++;
    mid   = (kind != 0) && (k >= 1);
    eack  = (kind == 3) && (k == end_k);
    eerr  = (kind == 1 || kind == 2) && (k == end_k);
    ewr   = (kind == 3) && (k == 3);
    ebusy = m_over || (mid && k <= end_k);
    chk("drop_ack", 32'(bus.drop_ack), 32'(eack));
    chk("drop_err", 32'(bus.drop_err), 32'(eerr));
    chk("mem_wr", 32'(bus.mem_wr), 32'(ewr));
    chk("lu_go", 32'(bus.lu_go), 32'(ewr));
    chk("busy", 32'(bus.busy), 32'(ebusy));
    if (mid) chk("mem_addr", 32'(bus.mem_addr), 32'(mv_col));
    if (ewr) begin
      chk("onoff_wr", 32'(bus.onoff_wr), 32'(e_onoff));
      chk("player_wr", 32'(bus.player_wr), 32'(e_player));
    end
    if (!mid) begin
      chk("cur_player", 32'(bus.cur_player), 32'(m_player));
      chk("move_count", 32'(bus.move_count), 32'(m_count));
      chk("game_over", 32'(bus.game_over), 32'(m_over));
      chk("winner", 32'(bus.winner), 32'(m_winner));
    end
    if (bus.drop_ack === 1'b1) begin ack_k = k; ack_total++; end
    if (bus.drop_err === 1'b1) begin err_k = k; err_total++; end
    if (bus.mem_wr === 1'b1) begin
      wr_k = k; wr_total++;
      cap_onoff = bus.onoff_wr; cap_player = bus.player_wr;
    end
    if (kind != 0 && k == end_k) begin
      m_player = p_player; m_count = p_count; m_over = p_over; m_winner = p_winner;
      kind = 0;
    end
  endtask

  task automatic step();
    @(negedge clk);
    compare();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.drop_req = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    m_player = 1'b0; m_count = '0; m_over = 1'b0; m_winner = '0;
    kind = 0;
  endtask

  task automatic preload(input int col, input logic [5:0] o, input logic [5:0] p);
    v_o[col] = o; v_p[col] = p;
    pl_col = 3'(col); pl_o = o; pl_p = p; pl_en = 1'b1;
    step();
    pl_en = 1'b0;
  endtask

  task automatic start_move(input int col, input logic [1:0] lu);
    logic [5:0] o;
    int h;
    bus.lu_result = lu;
    mv_col = 3'(col);
    p_player = m_player; p_count = m_count; p_over = m_over; p_winner = m_winner;
    if (m_over) begin
      kind = 0;
    end else if (col >= 7) begin
      kind = 1; end_k = 1;
    end else begin
      o = v_o[col];
      if (!is_therm(o) || o == 6'h3f) begin
        kind = 2; end_k = 3;
      end else begin
        kind = 3; end_k = 4 + RW;
        h = $countones(o);
        e_onoff = {o[4:0], 1'b1};
        e_player = v_p[col];
        e_player[h] = m_player;
        v_o[col] = e_onoff; v_p[col] = e_player;
        p_count = m_count + 6'd1;
        if (lu == 2'b01 || lu == 2'b10) begin
          p_over = 1'b1; p_winner = lu;
        end else if (p_count == 6'd42) begin
          p_over = 1'b1; p_winner = 2'b11;
        end else begin
          p_player = ~m_player;
        end
      end
    end
    k = -1;
    bus.drop_req = 1'b1;
    bus.drop_col = 3'(col);
    step();
    bus.drop_req = 1'b0;
  endtask

  task automatic run_move(input int col, input logic [1:0] lu);
    start_move(col, lu);
    for (int i = 0; i < 20 && kind != 0; i++) step();
    if (kind != 0) begin
      chk("move_timeout", 32'd1, 32'd0);
      kind = 0;
    end
    step();
  endtask

  int acks_before, wr_before, errs_before;

  initial begin
    reset = 1'b1;
    bus.drop_req = 1'b0; bus.drop_col = '0; bus.lu_result = '0;
    pl_en = 1'b0; pl_col = '0; pl_o = '0; pl_p = '0;
    kind = 0; k = 0; end_k = 0; mv_col = '0; e_onoff = '0; e_player = '0;
    ack_k = -9; err_k = -9; wr_k = -9; ack_total = 0; err_total = 0; wr_total = 0;
    cap_onoff = '0; cap_player = '0;
    @(posedge clk);
    do_reset();

    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    chk("rst_onoff_wr", 32'(bus.onoff_wr), 32'd0);
    chk("rst_player_wr", 32'(bus.player_wr), 32'd0);
    chk("rst_move_count", 32'(bus.move_count), 32'd0);
    for (int c = 0; c < 8; c++) preload(c, 6'b000000, 6'b000000);

    run_move(3, 2'b00);
    chk("t1_wr_cycle", 32'(wr_k), 32'd3);
    chk("t1_ack_cycle", 32'(ack_k), 32'd5);
    chk("t1_onoff_wr", 32'(cap_onoff), 32'b000001);
    chk("t1_player_wr", 32'(cap_player), 32'b000000);
    chk("t1_cur_player", 32'(bus.cur_player), 32'd1);
    chk("t1_move_count", 32'(bus.move_count), 32'd1);

    preload(2, 6'b000111, 6'b000010);
    run_move(2, 2'b00);
    chk("t2_onoff_wr", 32'(cap_onoff), 32'b001111);
    chk("t2_player_wr", 32'(cap_player), 32'b001010);
    chk("t2_cur_player", 32'(bus.cur_player), 32'd0);

    wr_before = wr_total; errs_before = err_total;
    run_move(7, 2'b00);
    chk("t3_inv_err_cycle", 32'(err_k), 32'd1);
    chk("t3_inv_count", 32'(bus.move_count), 32'd2);
    preload(0, 6'b111111, 6'b000000);
    run_move(0, 2'b00);
    chk("t3_full_err_cycle", 32'(err_k), 32'd3);
    preload(1, 6'b000101, 6'b000000);
    run_move(1, 2'b00);
    chk("t3_bad_err_cycle", 32'(err_k), 32'd3);
    chk("t3_no_write", 32'(wr_total), 32'(wr_before));
    chk("t3_err_count", 32'(err_total), 32'(errs_before + 3));

    run_move(4, 2'b10);
    chk("t4_game_over", 32'(bus.game_over), 32'd1);
    chk("t4_winner", 32'(bus.winner), 32'b10);
    acks_before = ack_total; wr_before = wr_total; errs_before = err_total;
    start_move(5, 2'b00);
    repeat (8) step();
    chk("t4_ignored_ack", 32'(ack_total), 32'(acks_before));
    chk("t4_ignored_err", 32'(err_total), 32'(errs_before));
    chk("t4_ignored_wr", 32'(wr_total), 32'(wr_before));
    chk("t4_busy", 32'(bus.busy), 32'd1);

    do_reset();
    for (int c = 0; c < 7; c++) preload(c, 6'b000000, 6'b000000);
    for (int i = 0; i < 42; i++) run_move(i % 7, (i == 10) ? 2'b11 : 2'b00);
    chk("t5_move_count", 32'(bus.move_count), 32'd42);
    chk("t5_game_over", 32'(bus.game_over), 32'd1);
    chk("t5_winner", 32'(bus.winner), 32'b11);

    do_reset();
    preload(3, 6'b000000, 6'b000000);
    start_move(3, 2'b00);
    repeat (3) step();
    acks_before = ack_total;
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("t6_rst_state_busy", 32'(bus.busy), 32'd0);
    reset = 1'b0;
    m_player = 1'b0; m_count = '0; m_over = 1'b0; m_winner = '0;
    kind = 0;
    repeat (4) step();
    chk("t6_no_ack", 32'(ack_total), 32'(acks_before));
    chk("t6_move_count", 32'(bus.move_count), 32'd0);
    chk("t6_onoff_wr", 32'(bus.onoff_wr), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
